// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared writeback types and constants
package riscv_pkg;

    // Register-file address width (32 architectural registers).
    localparam int unsigned RegAddrW = 5;

    // Source of the register-file write currently presented on the rf port.
    typedef enum logic [1:0] {
        WbNone = 2'd0,
        WbInt  = 2'd1,
        WbMem  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small FIFO holding integer results awaiting writeback
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   push_i, push_addr_i/data  enqueue one result (ignored when full unless popping)
//   pop_i                     dequeue the head entry (ignored when empty)
//   head_addr_o, head_data_o  oldest entry
//   count_o, empty_o, full_o  occupancy
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [RegAddrW-1:0]          push_addr_i,
    input  logic [XLEN-1:0]              push_data_i,
    input  logic                         pop_i,
    output logic [RegAddrW-1:0]          head_addr_o,
    output logic [XLEN-1:0]              head_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    logic [RegAddrW-1:0] addr_mem_q [DEPTH];
    logic [XLEN-1:0]     data_mem_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == DepthC);
    assign count_o     = count_q;
    assign head_addr_o = addr_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a full FIFO still
    // accepts a push when it is also being popped.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            addr_mem_q[wr_ptr_q] <= push_addr_i;
            data_mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter between integer and memory results
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_int_valid/res/waddr, o_int_ready   integer results (buffered, no backpressure)
//   i_mem_valid/data/waddr, o_mem_ready  memory results (valid/ready handshake)
//   o_rf_wen/waddr/wdata/src         registered register-file write port
//   o_overflow                       sticky: an integer result was dropped
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned INT_DEPTH  = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_int_valid,
    input  logic [XLEN-1:0]     i_int_res,
    input  logic [4:0]          i_int_waddr,
    output logic                o_int_ready,
    input  logic                i_mem_valid,
    input  logic [XLEN-1:0]     i_mem_data,
    input  logic [4:0]          i_mem_waddr,
    output logic                o_mem_ready,
    output logic                o_rf_wen,
    output logic [4:0]          o_rf_waddr,
    output logic [XLEN-1:0]     o_rf_wdata,
    output wb_src_e             o_rf_src,
    output logic                o_overflow
);

    localparam int unsigned CntW    = $clog2(INT_DEPTH + 1);
    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0]    DepthC     = CntW'(INT_DEPTH);
    localparam logic [StarveW-1:0] StarveMaxC = StarveW'(STARVE_MAX);

    logic [CntW-1:0]     buf_count;
    logic                buf_empty;
    logic                buf_full;
    logic [4:0]          head_addr;
    logic [XLEN-1:0]     head_data;
    logic                buf_push;
    logic                buf_pop;

    logic                int_cand;
    logic [4:0]          cand_addr;
    logic [XLEN-1:0]     cand_data;
    logic                int_win;
    logic                mem_win;
    logic                drop;

    logic [StarveW-1:0]  starve_q, starve_d;
    logic                rf_wen_q, rf_wen_d;
    logic [4:0]          rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]     rf_wdata_q, rf_wdata_d;
    wb_src_e             rf_src_q, rf_src_d;
    logic                overflow_q, overflow_d;

    wb_fifo #(
        .XLEN  (XLEN),
        .DEPTH (INT_DEPTH)
    ) u_int_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (buf_push),
        .push_addr_i (i_int_waddr),
        .push_data_i (i_int_res),
        .pop_i       (buf_pop),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .count_o     (buf_count),
        .empty_o     (buf_empty),
        .full_o      (buf_full)
    );

    // Arbitration. The incoming integer result may only bypass the buffer
    // when it is empty, otherwise older buffered results would be overtaken.
    always_comb begin
        int_cand  = !buf_empty || i_int_valid;
        cand_addr = buf_empty ? i_int_waddr : head_addr;
        cand_data = buf_empty ? i_int_res   : head_data;
        int_win   = !rst && int_cand && (!i_mem_valid || (starve_q == StarveMaxC));
        mem_win   = !rst && i_mem_valid && !int_win;
        buf_pop   = int_win && !buf_empty;
        buf_push  = !rst && i_int_valid && !(int_win && buf_empty);
        drop      = buf_push && buf_full && !buf_pop;
    end

    always_comb begin
        starve_d   = '0;
        overflow_d = overflow_q | drop;
        rf_wen_d   = 1'b0;
        rf_src_d   = WbNone;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (int_cand && mem_win) begin
            starve_d = (starve_q == StarveMaxC) ? starve_q : starve_q + 1'b1;
        end

        // x0 writes are consumed but never reach the register file.
        if (int_win) begin
            rf_wen_d   = (cand_addr != '0);
            rf_src_d   = WbInt;
            rf_waddr_d = cand_addr;
            rf_wdata_d = cand_data;
        end else if (mem_win) begin
            rf_wen_d   = (i_mem_waddr != '0);
            rf_src_d   = WbMem;
            rf_waddr_d = i_mem_waddr;
            rf_wdata_d = i_mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q   <= '0;
            overflow_q <= 1'b0;
            rf_wen_q   <= 1'b0;
            rf_src_q   <= WbNone;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            starve_q   <= starve_d;
            overflow_q <= overflow_d;
            rf_wen_q   <= rf_wen_d;
            rf_src_q   <= rf_src_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign o_int_ready = (buf_count < DepthC);
    assign o_mem_ready = mem_win;
    assign o_rf_wen    = rf_wen_q;
    assign o_rf_waddr  = rf_waddr_q;
    assign o_rf_wdata  = rf_wdata_q;
    assign o_rf_src    = rf_src_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;
    import riscv_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_int_valid;
    logic [XLEN-1:0] i_int_res;
    logic [4:0]      i_int_waddr;
    logic            o_int_ready;
    logic            i_mem_valid;
    logic [XLEN-1:0] i_mem_data;
    logic [4:0]      i_mem_waddr;
    logic            o_mem_ready;
    logic            o_rf_wen;
    logic [4:0]      o_rf_waddr;
    logic [XLEN-1:0] o_rf_wdata;
    wb_src_e         o_rf_src;
    logic            o_overflow;

    always #5 clk = ~clk;

    wb_arbiter #(
        .XLEN       (XLEN),
        .INT_DEPTH  (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_int_valid (i_int_valid),
        .i_int_res   (i_int_res),
        .i_int_waddr (i_int_waddr),
        .o_int_ready (o_int_ready),
        .i_mem_valid (i_mem_valid),
        .i_mem_data  (i_mem_data),
        .i_mem_waddr (i_mem_waddr),
        .o_mem_ready (o_mem_ready),
        .o_rf_wen    (o_rf_wen),
        .o_rf_waddr  (o_rf_waddr),
        .o_rf_wdata  (o_rf_wdata),
        .o_rf_src    (o_rf_src),
        .o_overflow  (o_overflow)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending integer results as a queue, plus the
    // expected registered writeback state.
    typedef struct packed {
        logic [4:0]      a;
        logic [XLEN-1:0] d;
    } ent_t;

    ent_t            mq[$];
    int              m_starve = 0;
    bit              m_ovf    = 0;
    bit              m_wen    = 0;
    wb_src_e         m_src    = WbNone;
    logic [4:0]      m_waddr  = '0;
    logic [XLEN-1:0] m_wdata  = '0;

    // Applies one cycle of inputs (called just after a falling edge),
    // checks the handshake mid-cycle and the registered outputs after the edge.
    task automatic cycle(input bit r, input bit iv, input logic [4:0] ia, input logic [XLEN-1:0] id,
                         input bit mv, input logic [4:0] ma, input logic [XLEN-1:0] md);
        bit   cand, iwin, mwin;
        ent_t c, inc;
        rst         = r;
        i_int_valid = iv;
        i_int_waddr = ia;
        i_int_res   = id;
        i_mem_valid = mv;
        i_mem_waddr = ma;
        i_mem_data  = md;
        #1;
        inc = {ia, id};
        if (r) begin
            chk("mem_ready_in_reset", o_mem_ready, 0);
            mq.delete();
            m_starve = 0;
            m_ovf    = 0;
            m_wen    = 0;
            m_src    = WbNone;
            m_waddr  = '0;
            m_wdata  = '0;
        end else begin
            cand = (mq.size() > 0) || iv;
            c    = (mq.size() > 0) ? mq[0] : inc;
            iwin = cand && (!mv || (m_starve == SMAX));
            mwin = mv && !iwin;
            chk("mem_ready", o_mem_ready, mwin);
            if (iwin) begin
                if (mq.size() > 0) begin
                    void'(mq.pop_front());
                    if (iv) mq.push_back(inc);
                end
            end else if (iv) begin
                if (mq.size() < DEPTH) mq.push_back(inc);
                else m_ovf = 1;
            end
            if (cand && mwin) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
            else m_starve = 0;
            if (iwin) begin
                m_src = WbInt; m_wen = (c.a != 0); m_waddr = c.a; m_wdata = c.d;
            end else if (mwin) begin
                m_src = WbMem; m_wen = (ma != 0); m_waddr = ma; m_wdata = md;
            end else begin
                m_src = WbNone; m_wen = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("rf_wen",    o_rf_wen,        m_wen);
        chk("rf_src",    64'(o_rf_src),   64'(m_src));
        chk("rf_waddr",  o_rf_waddr,      m_waddr);
        chk("rf_wdata",  o_rf_wdata,      m_wdata);
        chk("int_ready", o_int_ready,     mq.size() < DEPTH);
        chk("overflow",  o_overflow,      m_ovf);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(0, 0, 5'd0, '0, 0, 5'd0, '0);
    endtask

    initial begin
        int         int_writes;
        logic [4:0] int_order [2];

        rst = 1'b1; i_int_valid = 0; i_int_res = '0; i_int_waddr = '0;
        i_mem_valid = 0; i_mem_data = '0; i_mem_waddr = '0;
        @(negedge clk);

        // Reset, with inputs active to show they are ignored.
        cycle(1, 0, 5'd0, '0, 0, 5'd0, '0);
        cycle(1, 1, 5'd9, 32'hDEAD, 1, 5'd6, 32'hBEEF);
        chk("reset_wen", o_rf_wen, 0);
        chk("reset_src", 64'(o_rf_src), 64'(WbNone));
        chk("reset_int_ready", o_int_ready, 1);

        // Integer result alone bypasses the empty buffer.
        cycle(0, 1, 5'd5, 32'h1234, 0, 5'd0, '0);
        chk("int_only_wen", o_rf_wen, 1);
        chk("int_only_waddr", o_rf_waddr, 5);
        chk("int_only_wdata", o_rf_wdata, 32'h1234);
        chk("int_only_src", 64'(o_rf_src), 64'(WbInt));
        idle();

        // Collision: memory first, then the buffered integer result.
        cycle(0, 1, 5'd3, 32'hA, 1, 5'd4, 32'hB);
        chk("coll_mem_waddr", o_rf_waddr, 4);
        chk("coll_mem_src", 64'(o_rf_src), 64'(WbMem));
        idle();
        chk("coll_int_waddr", o_rf_waddr, 3);
        chk("coll_int_wdata", o_rf_wdata, 32'hA);
        idle();

        // Starvation: memory wins four times, then the integer result is forced in.
        cycle(0, 1, 5'd7, 32'h77, 1, 5'd8, 32'h80);
        chk("starve_mem0", 64'(o_rf_src), 64'(WbMem));
        for (int k = 1; k < 4; k++) begin
            cycle(0, 0, 5'd0, '0, 1, 5'(8 + k), 32'(32'h80 + k));
            chk("starve_mem", 64'(o_rf_src), 64'(WbMem));
        end
        cycle(0, 0, 5'd0, '0, 1, 5'd12, 32'h90);
        chk("starve_int_src", 64'(o_rf_src), 64'(WbInt));
        chk("starve_int_waddr", o_rf_waddr, 7);
        cycle(0, 0, 5'd0, '0, 1, 5'd13, 32'h91);
        chk("starve_cleared", 64'(o_rf_src), 64'(WbMem));
        idle();
        idle();

        // Overflow: three pulses against a continuously valid memory stream.
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 5'(10 + k), 32'(32'h100 + k), 1, 5'd20, 32'(32'h200 + k));
            if (k == 1) chk("ovf_ready_low", o_int_ready, 0);
            if (k == 2) chk("ovf_flag", o_overflow, 1);
        end
        int_writes = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(0, 0, 5'd0, '0, 1, 5'd21, 32'(32'h300 + k));
            if (o_rf_src == WbInt) begin
                if (int_writes < 2) int_order[int_writes] = o_rf_waddr;
                int_writes++;
            end
        end
        chk("ovf_int_writes", int_writes, 2);
        chk("ovf_first", int_order[0], 10);
        chk("ovf_second", int_order[1], 11);
        idle();

        // x0 destination: consumed, no write.
        cycle(0, 1, 5'd0, 32'hFFFF, 0, 5'd0, '0);
        chk("x0_wen", o_rf_wen, 0);
        chk("x0_src", 64'(o_rf_src), 64'(WbInt));
        idle();
        chk("x0_after_src", 64'(o_rf_src), 64'(WbNone));

        // Reset with two entries buffered discards them.
        cycle(0, 1, 5'd14, 32'h140, 1, 5'd22, 32'h220);
        cycle(0, 1, 5'd15, 32'h150, 1, 5'd23, 32'h230);
        chk("rst_buf_full", o_int_ready, 0);
        cycle(1, 0, 5'd0, '0, 0, 5'd0, '0);
        chk("rst_mid_ready", o_int_ready, 1);
        chk("rst_mid_ovf", o_overflow, 0);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("rst_mid_nowrite", o_rf_wen, 0);
        end

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), 32'($urandom()),
                  ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), 32'($urandom()));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
